// File: rtl/mac_mult_arbiter_if.sv
// Operand/result bundle between the lane fetch logic, the shared multiplier
// and the accumulator; tag identifies the lane that issued each result.
interface mac_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   i_valid;
  logic [NUM_REQ-1:0]   i_ready;
  logic [NUM_REQ-1:0]   i_a_sign;
  logic [4*NUM_REQ-1:0] i_a_exp;
  logic [8*NUM_REQ-1:0] i_a_mant;
  logic [NUM_REQ-1:0]   i_b_sign;
  logic [4*NUM_REQ-1:0] i_b_exp;
  logic [8*NUM_REQ-1:0] i_b_mant;
  logic                 o_valid;
  logic                 o_ready;
  logic                 o_sign;
  logic [4:0]           o_exp;
  logic [17:0]          o_mant;
  logic [TAG_W-1:0]     o_tag;
  logic                 o_busy;

  modport master (
    output i_valid, i_a_sign, i_a_exp, i_a_mant, i_b_sign, i_b_exp, i_b_mant, o_ready,
    input  i_ready, o_valid, o_sign, o_exp, o_mant, o_tag, o_busy
  );

  modport slave (
    input  i_valid, i_a_sign, i_a_exp, i_a_mant, i_b_sign, i_b_exp, i_b_mant, o_ready,
    output i_ready, o_valid, o_sign, o_exp, o_mant, o_tag, o_busy
  );
endinterface

// File: rtl/mac_mult_arbiter.sv
// Round-robin shared sign/exponent/mantissa multiplier with a two-stage
// valid/ready pipeline (operand register, result register) and requester tags.
module mac_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  mac_mult_arbiter_if.slave bus
);

  function automatic logic [4:0] exp_sum(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [17:0] mant_prod(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    return {2'b00, p};
  endfunction

  logic             vld_p0_q, vld_p0_d;
  logic             vld_p1_q, vld_p1_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             s1_load, s0_free, accept;
  logic             gnt_found;
  logic [TAG_W-1:0] gnt_idx;

  logic             sel_a_sign, sel_b_sign;
  logic [3:0]       sel_a_exp, sel_b_exp;
  logic [7:0]       sel_a_mant, sel_b_mant;

  logic             a_sign_p0_q, b_sign_p0_q;
  logic [3:0]       a_exp_p0_q, b_exp_p0_q;
  logic [7:0]       a_mant_p0_q, b_mant_p0_q;
  logic [TAG_W-1:0] tag_p0_q;

  logic             sign_p1_q;
  logic [4:0]       exp_p1_q;
  logic [17:0]      mant_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  // Two passes: first from rr_ptr upward, then from 0; wraps at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && bus.i_valid[j] && (TAG_W'(j) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = TAG_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && bus.i_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAG_W'(j);
      end
    end
  end

  always_comb begin
    sel_a_sign = 1'b0;
    sel_a_exp  = '0;
    sel_a_mant = '0;
    sel_b_sign = 1'b0;
    sel_b_exp  = '0;
    sel_b_mant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_idx == TAG_W'(j)) begin
        sel_a_sign = bus.i_a_sign[j];
        sel_a_exp  = bus.i_a_exp[4*j +: 4];
        sel_a_mant = bus.i_a_mant[8*j +: 8];
        sel_b_sign = bus.i_b_sign[j];
        sel_b_exp  = bus.i_b_exp[4*j +: 4];
        sel_b_mant = bus.i_b_mant[8*j +: 8];
      end
    end
  end

  assign s1_load  = vld_p0_q && (!vld_p1_q || bus.o_ready);
  assign s0_free  = !vld_p0_q || s1_load;
  // Gated by rst so no lane sees a strobe while the pipe is held in reset.
  assign accept   = !rst && s0_free && gnt_found;
  assign vld_p0_d = accept || (vld_p0_q && !s0_free);
  assign vld_p1_d = s1_load || (vld_p1_q && !bus.o_ready);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept)
      rr_ptr_d = (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    bus.i_ready = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (accept && (gnt_idx == TAG_W'(j)))
        bus.i_ready[j] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Stage p0: captured operands of the granted lane
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sign_p0_q <= sel_a_sign;
      a_exp_p0_q  <= sel_a_exp;
      a_mant_p0_q <= sel_a_mant;
      b_sign_p0_q <= sel_b_sign;
      b_exp_p0_q  <= sel_b_exp;
      b_mant_p0_q <= sel_b_mant;
      tag_p0_q    <= gnt_idx;
    end
  end

  // Stage p1: product registers, visible on the result port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_p1_q <= 1'b0;
      exp_p1_q  <= '0;
      mant_p1_q <= '0;
      tag_p1_q  <= '0;
    end else if (s1_load) begin
      sign_p1_q <= a_sign_p0_q ^ b_sign_p0_q;
      exp_p1_q  <= exp_sum(a_exp_p0_q, b_exp_p0_q);
      mant_p1_q <= mant_prod(a_mant_p0_q, b_mant_p0_q);
      tag_p1_q  <= tag_p0_q;
    end
  end

  assign bus.o_valid = vld_p1_q;
  assign bus.o_sign  = sign_p1_q;
  assign bus.o_exp   = exp_p1_q;
  assign bus.o_mant  = mant_p1_q;
  assign bus.o_tag   = tag_p1_q;
  assign bus.o_busy  = vld_p0_q | vld_p1_q;

endmodule

// File: tb/tb_mac_mult_arbiter.sv
// Scoreboard bench for mac_mult_arbiter: a 4-lane instance under random and
// directed traffic, plus a 3-lane instance for the non-power-of-two wrap.
module tb_mac_mult_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;

  mac_mult_arbiter_if #(.NUM_REQ(4)) bus4 ();
  mac_mult_arbiter_if #(.NUM_REQ(3)) bus3 ();

  mac_mult_arbiter #(.NUM_REQ(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mac_mult_arbiter #(.NUM_REQ(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int s;
    int e;
    int m;
    int tag;
  } exp_t;

  exp_t q[$];
  int   rr  = 0;
  int   cyc = 0;
  int   gcnt[NR];
  int   seen[NR];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pipe holds at most two results, the oldest is visible two
  // cycles after its grant, and a new grant is possible unless two are held
  // and the consumer stalls.
  always @(negedge clk or posedge rst) begin : mon
    bit ev;
    int g;
    int ndx;
    int er;
    if (rst) begin
      q.delete();
      rr = 0;
    end else begin
      ev = (q.size() > 0) && (cyc - q[0].t >= 2);
      chk("o_valid", bus4.o_valid, ev);
      chk("o_busy", bus4.o_busy, q.size() > 0);
      g = -1;
      if (q.size() < 2 || bus4.o_ready) begin
        for (int i = 0; i < NR; i++) begin
          ndx = (rr + i) % NR;
          if (g < 0 && bus4.i_valid[ndx]) g = ndx;
        end
      end
      er = (g >= 0) ? (1 << g) : 0;
      chk("i_ready", bus4.i_ready, er);
      if (ev) begin
        chk("o_sign", bus4.o_sign, q[0].s);
        chk("o_exp", bus4.o_exp, q[0].e);
        chk("o_mant", bus4.o_mant, q[0].m);
        chk("o_tag", bus4.o_tag, q[0].tag);
        if (bus4.o_ready) void'(q.pop_front());
      end
      if (g >= 0) begin
        q.push_back('{cyc,
                      int'(bus4.i_a_sign[g] ^ bus4.i_b_sign[g]),
                      int'(bus4.i_a_exp[4*g +: 4]) + int'(bus4.i_b_exp[4*g +: 4]),
                      int'(bus4.i_a_mant[8*g +: 8]) * int'(bus4.i_b_mant[8*g +: 8]),
                      g});
        rr = (g + 1) % NR;
        gcnt[g]++;
      end
      cyc++;
    end
  end

  task automatic set_ops(input int k);
    bus4.i_a_sign[k] = 1'($urandom);
    bus4.i_b_sign[k] = 1'($urandom);
    if ($urandom_range(7) == 0) begin
      bus4.i_a_exp[4*k +: 4]  = 4'd15;
      bus4.i_a_mant[8*k +: 8] = 8'd255;
    end else begin
      bus4.i_a_exp[4*k +: 4]  = 4'($urandom);
      bus4.i_a_mant[8*k +: 8] = 8'($urandom);
    end
    bus4.i_b_exp[4*k +: 4]  = 4'($urandom);
    bus4.i_b_mant[8*k +: 8] = 8'($urandom);
  endtask

  task automatic step_hold();
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) begin
      if (gcnt[k] != seen[k]) begin
        seen[k] = gcnt[k];
        set_ops(k);
      end
    end
  endtask

  task automatic step_rand(input int rdy_pct);
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) begin
      if (gcnt[k] != seen[k]) begin
        seen[k] = gcnt[k];
        bus4.i_valid[k] = 1'($urandom);
        set_ops(k);
      end else if (bus4.i_valid[k]) begin
        if ($urandom_range(9) == 0) bus4.i_valid[k] = 1'b0;
      end else if ($urandom_range(1) == 1) begin
        bus4.i_valid[k] = 1'b1;
        set_ops(k);
      end
    end
    bus4.o_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic issue_one(input int k, input bit as, input int ae, input int am,
                           input bit bs, input int be, input int bm, output int lat);
    int c;
    @(posedge clk); #1;
    bus4.i_valid            = '0;
    bus4.i_valid[k]         = 1'b1;
    bus4.i_a_sign[k]        = as;
    bus4.i_a_exp[4*k +: 4]  = 4'(ae);
    bus4.i_a_mant[8*k +: 8] = 8'(am);
    bus4.i_b_sign[k]        = bs;
    bus4.i_b_exp[4*k +: 4]  = 4'(be);
    bus4.i_b_mant[8*k +: 8] = 8'(bm);
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (gcnt[k] == seen[k] && c < 20);
    chk("grant_wait", gcnt[k] != seen[k], 1);
    seen[k] = gcnt[k];
    lat = c;
    @(posedge clk); #1;
    bus4.i_valid[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int acc;
    rst = 1'b1;
    bus4.i_valid = '0; bus4.i_a_sign = '0; bus4.i_a_exp = '0; bus4.i_a_mant = '0;
    bus4.i_b_sign = '0; bus4.i_b_exp = '0; bus4.i_b_mant = '0; bus4.o_ready = 1'b1;
    bus3.i_valid = '0; bus3.i_a_sign = '0; bus3.i_a_exp = '0; bus3.i_a_mant = '0;
    bus3.i_b_sign = '0; bus3.i_b_exp = '0; bus3.i_b_mant = '0; bus3.o_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      gcnt[k] = 0;
      seen[k] = 0;
      set_ops(k);
    end
    bus4.i_valid = '1;

    // Reset state with every lane requesting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ready", bus4.i_ready, 0);
    chk("rst_o_valid", bus4.o_valid, 0);
    chk("rst_o_busy", bus4.o_busy, 0);
    chk("rst_o_sign", bus4.o_sign, 0);
    chk("rst_o_exp", bus4.o_exp, 0);
    chk("rst_o_mant", bus4.o_mant, 0);
    chk("rst_o_tag", bus4.o_tag, 0);
    bus4.i_valid = '0;
    rst = 1'b0;

    // Three-lane wrap: after lane 2 the pointer returns to lane 0
    @(posedge clk); #1;
    bus3.i_valid = 3'b100;
    @(negedge clk); #1;
    chk("w3_grant2", bus3.i_ready, 3'b100);
    @(posedge clk); #1;
    bus3.i_valid = 3'b101;
    @(negedge clk); #1;
    chk("w3_grant0", bus3.i_ready, 3'b001);
    @(posedge clk); #1;
    bus3.i_valid = 3'b100;
    @(negedge clk); #1;
    chk("w3_grant2b", bus3.i_ready, 3'b100);
    chk("w3_valid", bus3.o_valid, 1);
    chk("w3_tag_a", bus3.o_tag, 2);
    @(posedge clk); #1;
    bus3.i_valid = 3'b000;
    @(negedge clk); #1;
    chk("w3_tag_b", bus3.o_tag, 0);
    @(negedge clk); #1;
    chk("w3_tag_c", bus3.o_tag, 2);

    // All lanes requesting back to back from pointer 0
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) set_ops(k);
    bus4.i_valid = '1;
    bus4.o_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      chk("rr_grant", bus4.i_ready, 1 << (c % 4));
      if (c >= 2) chk("rr_tag", bus4.o_tag, (c - 2) % 4);
      step_hold();
    end
    bus4.i_valid = '0;
    repeat (4) @(posedge clk);

    // Single request, two-cycle latency
    issue_one(2, 1'b0, 3, 200, 1'b1, 5, 100, lat);
    chk("single_lat", lat, 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("single_valid", bus4.o_valid, 1);
    chk("single_sign", bus4.o_sign, 1);
    chk("single_exp", bus4.o_exp, 8);
    chk("single_mant", bus4.o_mant, 20000);
    chk("single_tag", bus4.o_tag, 2);
    @(negedge clk); #1;
    chk("single_idle", bus4.o_busy, 0);

    // Largest operands
    issue_one(1, 1'b1, 15, 255, 1'b1, 15, 255, lat);
    @(negedge clk);
    @(negedge clk); #1;
    chk("max_sign", bus4.o_sign, 0);
    chk("max_exp", bus4.o_exp, 30);
    chk("max_mant", bus4.o_mant, 65025);
    chk("max_mant_hi", bus4.o_mant[17:16], 0);
    repeat (3) @(posedge clk);

    // Stalled consumer: two accepts then all strobes low
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) set_ops(k);
    bus4.i_valid = '1;
    bus4.o_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (bus4.i_ready != '0) acc++;
      if (c >= 2) chk("bp_valid", bus4.o_valid, 1);
      step_hold();
    end
    chk("bp_accepts", acc, 2);
    bus4.i_valid = '0;
    bus4.o_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Random traffic with varying consumer stalls
    repeat (300) step_rand(70);
    repeat (150) step_rand(30);
    repeat (150) step_rand(100);

    // Asynchronous reset with both stages full
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) set_ops(k);
    bus4.i_valid = '1;
    bus4.o_ready = 1'b0;
    repeat (3) step_hold();
    @(posedge clk); #3;
    chk("pre_rst_busy", bus4.o_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_o_valid", bus4.o_valid, 0);
    chk("arst_o_busy", bus4.o_busy, 0);
    chk("arst_i_ready", bus4.i_ready, 0);
    bus4.i_valid = 4'b1010;
    bus4.o_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int k = 0; k < NR; k++) seen[k] = gcnt[k];
    @(negedge clk); #1;
    chk("post_rst_grant", bus4.i_ready, 4'b0010);
    @(posedge clk); #1;
    seen[1] = gcnt[1];
    bus4.i_valid = 4'b1000;
    @(posedge clk); #1;
    seen[3] = gcnt[3];
    bus4.i_valid = '0;

    repeat (200) step_rand(60);

    @(posedge clk); #1;
    bus4.i_valid = '0;
    bus4.o_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() > 0; c++) @(posedge clk);
    chk("drain", q.size(), 0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
